s5378_scan_bist: RTL

S5378_SCAN_BIST -- requirements
Module: s5378_scan_bist

---
 rtl/s5378_scan_bist.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/s5378_scan_bist.sv
// Scan-based BIST for an s5378 cone: LFSR fills the scan chain and primary inputs, the cone response is captured and compacted into a MISR.
// One pattern takes N_FF shift cycles + 1 capture + 1 compact; start is honoured only in IDLE or DONE.
module s5378_scan_bist #(
    parameter int                 N_FF      = 16,
    parameter int                 N_PI      = 20,
    parameter int                 N_PO      = 1,
    parameter int                 N_PAT     = 256,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter logic [LFSR_W-1:0]  LFSR_POLY = 16'hB400,
    parameter int                 MISR_W    = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY = 16'h1021
) (
    input  logic              CK,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_PI-1:0]   pi_out,
    output logic [N_FF-1:0]   ff_q,
    input  logic [N_FF-1:0]   ff_d,
    input  logic [N_PO-1:0]   po_in,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic [15:0]       pat_count
);

    localparam int SC_W  = $clog2(N_FF + 1);
    localparam int N_SL  = (N_FF + MISR_W - 1) / MISR_W;
    // A zero seed would lock the LFSR, so substitute 1.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_COMPACT, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
    logic [MISR_W-1:0]   r_misr;
    logic [N_PI-1:0]     r_pi, w_pi_nxt;
    logic [N_FF-1:0]     r_ff_q;
    logic [15:0]         r_pat, w_pat_inc;
    logic [SC_W-1:0]     r_shift_cnt;
    logic                w_last_shift;
    logic [MISR_W-1:0]   w_po_ext, w_fold;
    logic [N_SL*MISR_W-1:0] w_ff_pad;

    function automatic logic [MISR_W-1:0] f_misr_step(input logic [MISR_W-1:0] m,
                                                      input logic [MISR_W-1:0] x);
        return ({m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : '0)) ^ x;
    endfunction

    assign w_lfsr_nxt   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
    assign w_last_shift = (r_shift_cnt == SC_W'(N_FF - 1));
    assign w_pat_inc    = r_pat + 16'd1;

    always_comb begin
        w_pi_nxt = '0;
        for (int i = 0; i < N_PI; i++) w_pi_nxt[i] = w_lfsr_nxt[i % LFSR_W];
    end

    always_comb begin
        w_po_ext = '0;
        for (int i = 0; i < N_PO && i < MISR_W; i++) w_po_ext[i] = po_in[i];
    end

    // Scan chain folded to MISR width; the top slice is zero-padded.
    always_comb begin
        w_ff_pad = '0;
        w_ff_pad[N_FF-1:0] = r_ff_q;
        w_fold = '0;
        for (int s = 0; s < N_SL; s++) w_fold = w_fold ^ w_ff_pad[s*MISR_W +: MISR_W];
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_SHIFT;
            S_SHIFT:        if (w_last_shift) w_state_nxt = S_CAPTURE;
            S_CAPTURE:      w_state_nxt = S_COMPACT;
            S_COMPACT:      w_state_nxt = (w_pat_inc == 16'(N_PAT)) ? S_DONE : S_SHIFT;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Flags are decoded from the next state so they are registered yet aligned with r_state.
    always_comb begin
        w_busy_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPTURE) ||
                     (w_state_nxt == S_COMPACT);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_pi        <= '0;
            r_ff_q      <= '0;
            r_lfsr      <= SEED_SAFE;
            r_misr      <= '0;
            r_pat       <= '0;
            r_shift_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_lfsr      <= SEED_SAFE;
                        r_misr      <= '0;
                        r_pat       <= '0;
                        r_shift_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_ff_q      <= {r_ff_q[N_FF-2:0], r_lfsr[0]};
                    r_shift_cnt <= r_shift_cnt + SC_W'(1);
                    r_lfsr      <= w_lfsr_nxt;
                    if (w_last_shift) r_pi <= w_pi_nxt;
                end
                S_CAPTURE: begin
                    r_ff_q <= ff_d;
                    r_misr <= f_misr_step(r_misr, w_po_ext);
                end
                S_COMPACT: begin
                    r_misr      <= f_misr_step(r_misr, w_fold);
                    r_pat       <= w_pat_inc;
                    r_shift_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign pi_out    = r_pi;
    assign ff_q      = r_ff_q;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_misr;
    assign pat_count = r_pat;

endmodule
